// File: rtl/qos_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : qos_cfg_bank
// Purpose  : Shadow/active QoS configuration bank. Shadow writes are committed
//            atomically on a scheduler round boundary after validation.
//            Optional readback port enabled by defining QOS_CFG_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module qos_cfg_bank #(
   parameter int  QUEUE_QUANTITY    = 4,
   parameter int  TABLE_SIZE        = 8,
   parameter int  MAX_WEIGHT        = 64,
   parameter int  TIPOS_ROUND_ROBIN = 3,
   localparam int W = $clog2(MAX_WEIGHT),
   localparam int R = $clog2(TIPOS_ROUND_ROBIN),
   localparam int Q = $clog2(QUEUE_QUANTITY),
   localparam int N = 1 + QUEUE_QUANTITY + 2*TABLE_SIZE,
   localparam int A = $clog2(N)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [A-1:0]                 wr_addr,
   input  logic [W-1:0]                 wr_data,
   output logic                         wr_ready,
   input  logic                         iniciar,
   input  logic                         frontera,
   input  logic                         abortar,
   output logic [R-1:0]                 seleccion_roundRobin_out,
   output logic [QUEUE_QUANTITY*W-1:0]  pesos_out,
   output logic [TABLE_SIZE*W-1:0]      pesosArbitraje_out,
   output logic [TABLE_SIZE*Q-1:0]      selecciones_out,
   output logic                         busy,
   output logic                         commit_done,
`ifdef QOS_CFG_READBACK_EN
   input  logic [A-1:0]                 rd_addr,
   output logic [W-1:0]                 rd_data,
`endif
   output logic [1:0]                   cfg_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t         state;
   logic [R-1:0]   rr_sh;
   logic [W-1:0]   pesos_sh [QUEUE_QUANTITY];
   logic [W-1:0]   arb_sh   [TABLE_SIZE];
   logic [Q-1:0]   sel_sh   [TABLE_SIZE];
   logic           err_addr;
   logic           err_commit;
   logic           shadow_ok;

   assign wr_ready = (state == IDLE);
   assign busy     = (state == PEND) || (state == COMMIT);
   assign cfg_err  = {err_commit, err_addr};

   // Shadow bank: written only while IDLE, so it is stable through PEND/COMMIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_sh    <= '0;
         err_addr <= 1'b0;
         for (int i = 0; i < QUEUE_QUANTITY; i++) pesos_sh[i] <= W'(1);
         for (int i = 0; i < TABLE_SIZE; i++) begin
            arb_sh[i] <= W'(1);
            sel_sh[i] <= Q'(i % QUEUE_QUANTITY);
         end
      end else if (wr_valid && wr_ready) begin
         if (int'(wr_addr) >= N) err_addr <= 1'b1;
         if (wr_addr == '0) rr_sh <= wr_data[R-1:0];
         for (int i = 0; i < QUEUE_QUANTITY; i++)
            if (int'(wr_addr) == 1 + i) pesos_sh[i] <= wr_data;
         for (int i = 0; i < TABLE_SIZE; i++) begin
            if (int'(wr_addr) == 1 + QUEUE_QUANTITY + i) arb_sh[i] <= wr_data;
            if (int'(wr_addr) == 1 + QUEUE_QUANTITY + TABLE_SIZE + i) sel_sh[i] <= wr_data[Q-1:0];
         end
      end
   end

   // A zero weight would starve a queue, so such a configuration is rejected
   always_comb begin
      shadow_ok = 1'b1;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         if (pesos_sh[i] == '0) shadow_ok = 1'b0;
      for (int i = 0; i < TABLE_SIZE; i++)
         if (arb_sh[i] == '0) shadow_ok = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                    <= IDLE;
         commit_done              <= 1'b0;
         err_commit               <= 1'b0;
         seleccion_roundRobin_out <= '0;
         for (int i = 0; i < QUEUE_QUANTITY; i++) pesos_out[i*W +: W] <= W'(1);
         for (int i = 0; i < TABLE_SIZE; i++) begin
            pesosArbitraje_out[i*W +: W] <= W'(1);
            selecciones_out[i*Q +: Q]    <= Q'(i % QUEUE_QUANTITY);
         end
      end else begin
         commit_done <= 1'b0;
         case (state)
            IDLE: begin
               if (iniciar && frontera) state <= COMMIT;
               else if (iniciar)        state <= PEND;
            end
            PEND: begin
               if (abortar)       state <= IDLE;
               else if (frontera) state <= COMMIT;
            end
            COMMIT: begin
               state <= IDLE;
               if (shadow_ok) begin
                  commit_done              <= 1'b1;
                  seleccion_roundRobin_out <= rr_sh;
                  for (int i = 0; i < QUEUE_QUANTITY; i++) pesos_out[i*W +: W] <= pesos_sh[i];
                  for (int i = 0; i < TABLE_SIZE; i++) begin
                     pesosArbitraje_out[i*W +: W] <= arb_sh[i];
                     selecciones_out[i*Q +: Q]    <= sel_sh[i];
                  end
               end else begin
                  err_commit <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef QOS_CFG_READBACK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= '0;
         if (rd_addr == '0) rd_data <= W'(rr_sh);
         for (int i = 0; i < QUEUE_QUANTITY; i++)
            if (int'(rd_addr) == 1 + i) rd_data <= pesos_sh[i];
         for (int i = 0; i < TABLE_SIZE; i++) begin
            if (int'(rd_addr) == 1 + QUEUE_QUANTITY + i) rd_data <= arb_sh[i];
            if (int'(rd_addr) == 1 + QUEUE_QUANTITY + TABLE_SIZE + i) rd_data <= W'(sel_sh[i]);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qos_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_qos_cfg_bank
// Purpose  : Scoreboard bench for qos_cfg_bank with a behavioural config model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qos_cfg_bank;
   localparam int QQ = 4;
   localparam int TS = 8;
   localparam int W  = 6;
   localparam int R  = 2;
   localparam int Q  = 2;
   localparam int N  = 1 + QQ + 2*TS;
   localparam int A  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic [A-1:0]      wr_addr;
   logic [W-1:0]      wr_data;
   logic              wr_ready;
   logic              iniciar, frontera, abortar;
   logic [R-1:0]      rr_out;
   logic [QQ*W-1:0]   pesos_out;
   logic [TS*W-1:0]   arb_out;
   logic [TS*Q-1:0]   sel_out;
   logic              busy, commit_done;
   logic [1:0]        cfg_err;
`ifdef QOS_CFG_READBACK_EN
   logic [A-1:0]      rd_addr = '0;
   logic [W-1:0]      rd_data;
`endif

   qos_cfg_bank dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .iniciar(iniciar), .frontera(frontera), .abortar(abortar),
      .seleccion_roundRobin_out(rr_out), .pesos_out(pesos_out),
      .pesosArbitraje_out(arb_out), .selecciones_out(sel_out),
      .busy(busy), .commit_done(commit_done),
`ifdef QOS_CFG_READBACK_EN
      .rd_addr(rd_addr), .rd_data(rd_data),
`endif
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [R-1:0]    rr;
      logic [QQ*W-1:0] p;
      logic [TS*W-1:0] a;
      logic [TS*Q-1:0] s;
      int              at;
   } cfg_t;

   cfg_t exp_q[$];

   // Behavioural model: shadow values as plain integers, phase 0/1/2 = idle/pending/committing
   int         m_rr;
   int         m_p [QQ];
   int         m_a [TS];
   int         m_s [TS];
   int         mst;
   logic [1:0] m_err;
   cfg_t       m_act;

   function automatic cfg_t shadow_cfg();
      cfg_t c;
      c.rr = R'(m_rr);
      c.p  = '0;
      c.a  = '0;
      c.s  = '0;
      c.at = 0;
      for (int i = 0; i < QQ; i++) c.p[i*W +: W] = W'(m_p[i]);
      for (int i = 0; i < TS; i++) begin
         c.a[i*W +: W] = W'(m_a[i]);
         c.s[i*Q +: Q] = Q'(m_s[i]);
      end
      return c;
   endfunction

   function automatic bit shadow_valid();
      for (int i = 0; i < QQ; i++) if (m_p[i] == 0) return 1'b0;
      for (int i = 0; i < TS; i++) if (m_a[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      m_rr = 0;
      for (int i = 0; i < QQ; i++) m_p[i] = 1;
      for (int i = 0; i < TS; i++) begin
         m_a[i] = 1;
         m_s[i] = i % QQ;
      end
      mst    = 0;
      m_err  = 2'b00;
      m_act  = shadow_cfg();
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_state();
      chk("busy", busy, mst != 0);
      chk("wr_ready", wr_ready, mst == 0);
      chk("cfg_err", cfg_err, m_err);
      chk("rr_out", rr_out, m_act.rr);
      chk("pesos_out", pesos_out, m_act.p);
      chk("arb_out", arb_out, m_act.a);
      chk("sel_out", sel_out, m_act.s);
   endtask

   // Monitor: every commit_done must match the oldest expected commit
   initial begin
      cfg_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst === 1'b1 && commit_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_commit_done at cycle %0d: actual=1 required=0", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("commit_cycle", cyc, e.at);
               chk("commit_rr", rr_out, e.rr);
               chk("commit_pesos", pesos_out, e.p);
               chk("commit_arb", arb_out, e.a);
               chk("commit_sel", sel_out, e.s);
            end
         end
      end
   end

   task automatic step(input logic wv, input int wa, input int wd,
                       input logic ini, input logic fr, input logic ab);
      cfg_t c;
      @(negedge clk);
      wr_valid = wv;
      wr_addr  = A'(wa);
      wr_data  = W'(wd);
      iniciar  = ini;
      frontera = fr;
      abortar  = ab;
      if (wv && mst == 0) begin
         if (wa == 0)            m_rr = wd % (1 << R);
         else if (wa <= QQ)      m_p[wa-1] = wd;
         else if (wa <= QQ + TS) m_a[wa-1-QQ] = wd;
         else if (wa < N)        m_s[wa-1-QQ-TS] = wd % (1 << Q);
         else                    m_err[0] = 1'b1;
      end
      case (mst)
         0: begin
            if (ini && fr) mst = 2;
            else if (ini)  mst = 1;
         end
         1: begin
            if (ab)      mst = 0;
            else if (fr) mst = 2;
         end
         default: begin
            mst = 0;
            if (shadow_valid()) begin
               m_act = shadow_cfg();
               c     = m_act;
               c.at  = cyc + 1;
               exp_q.push_back(c);
            end else begin
               m_err[1] = 1'b1;
            end
         end
      endcase
      @(posedge clk);
      #2;
      chk_state();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      wr_valid = 1'b0;
      iniciar  = 1'b0;
      frontera = 1'b0;
      abortar  = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      chk("rst_commit_done", commit_done, 1'b0);
      chk("rst_pesos", pesos_out, {QQ{W'(1)}});
      chk("rst_arb", arb_out, {TS{W'(1)}});
      chk("rst_sel", sel_out, 16'hE4E4);
      chk_state();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      iniciar  = 1'b0;
      frontera = 1'b0;
      abortar  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      idle_steps(1);

      // Write weight, commit held pending until the round boundary
      step(1'b1, 1, 5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2, 9, 1'b0, 1'b0, 1'b0);
      idle_steps(2);
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      idle_steps(3);
      chk("pesos0_is_5", pesos_out[W-1:0], 5);

      // Zero weight rejects the commit
      step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      idle_steps(3);
      chk("reject_err", cfg_err, 2'b10);

      // Repair and commit with a same-cycle write
      step(1'b1, 2, 7, 1'b0, 1'b0, 1'b0);
      step(1'b1, 20, 3, 1'b1, 1'b1, 1'b0);
      idle_steps(3);

      // Out-of-range address
      step(1'b1, N, 9, 1'b0, 1'b0, 1'b0);
      step(1'b1, 31, 9, 1'b0, 1'b0, 1'b0);
      idle_steps(1);

      // Abort wins over frontera
      step(1'b1, 6, 40, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      idle_steps(3);

      // Reset mid-PEND discards the commit
      step(1'b1, 4, 33, 1'b0, 1'b0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      idle_steps(3);

      for (int k = 0; k < 600; k++) begin
         int wa, wd;
         wa = ($urandom % 10 == 0) ? N + int'($urandom % 3) : int'($urandom % N);
         wd = ($urandom % 16 == 0) ? 0 : 1 + int'($urandom % 63);
         if ($urandom % 200 == 0) do_reset();
         step(1'($urandom % 2), wa, wd, ($urandom % 4) == 0,
              ($urandom % 3) == 0, ($urandom % 5) == 0);
      end

      idle_steps(4);
      chk("pending_commits", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
